// File: rtl/echo_pkg.sv
// Shared definitions for the UART transmit arbiter and the units that feed it.
package echo_pkg;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    ACCEPT,
    ACK,
    HOLD
  } state_t;

  // Default build: four requesters, 255-cycle handshake timeout.
  localparam int NUM_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 255;

  // Byte tag carried in the LSB of sonar packet bytes.
  localparam logic TAG_DISTANCE = 1'b0;
  localparam logic TAG_ANGLE    = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART transmit arbiter.
//
// Handshake: a requester raises req[i] with req_data/req_last stable and
// holds it until it sees ack[i] high at a clock edge; from the following
// cycle it either drops req[i] or presents its next byte. On the transmitter
// side, data_wen low for one cycle writes data, and the transmitter signals
// that it took the byte by pulling tx_rdy low.
interface uart_tx_arbiter_if
  import echo_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_last;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_rdy;
  logic                 data_wen;
  logic [7:0]           data;
  logic                 busy;
  logic                 timeout_err;
  state_t               dbg_state;

  modport master (
    output req, req_last, req_data, tx_rdy,
    input  ack, data_wen, data, busy, timeout_err, dbg_state
  );

  modport slave (
    input  req, req_last, req_data, tx_rdy,
    output ack, data_wen, data, busy, timeout_err, dbg_state
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk N candidates starting at ptr; the first hit wins.
  always_comb begin
    int            j;
    logic [IW-1:0] j_idx;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    j_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      j_idx = IW'(j);
      if (!found && req[j_idx]) begin
        found = 1'b1;
        idx   = j_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// sources, with a packet lock that keeps multi-byte messages contiguous.
module uart_tx_arbiter
  import echo_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_REQ - 1);

  state_t state, state_next;

  logic [IW-1:0]      ptr_q, ptr_d, grant_q, grant_d, grant_inc, pick_idx;
  logic               pick_found;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic               cnt_hit;
  logic               last_q, last_d;
  logic [7:0]         data_q, data_d;
  logic               data_wen_q, data_wen_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               req_g;
  logic [7:0]         byte_of [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign byte_of[g] = bus.req_data[8*g +: 8];
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The pointer advance wraps at NUM_REQ, which need not be a power of two.
  assign grant_inc = (grant_q == IDX_MAX) ? '0 : grant_q + IW'(1);
  // Saturating count; a hit means this cycle completes TIMEOUT waits.
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign cnt_hit   = (cnt_inc == CNT_MAX);
  assign req_g     = bus.req[grant_q];

  // State register plus every registered output; reset abandons any byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      data_q     <= '0;
      data_wen_q <= 1'b1;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_next;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      data_q     <= data_d;
      data_wen_q <= data_wen_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (pick_found) state_next = WAIT_RDY;
      WAIT_RDY: if (bus.tx_rdy) state_next = ACCEPT;
      ACCEPT:   if (!bus.tx_rdy || cnt_hit) state_next = ACK;
      ACK:      state_next = last_q ? IDLE : HOLD;
      HOLD: begin
        if (req_g)        state_next = WAIT_RDY;
        else if (cnt_hit) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Next values of the datapath and output registers.
  always_comb begin
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    data_d     = data_q;
    data_wen_d = 1'b1;
    err_d      = 1'b0;
    busy_d     = (state_next != IDLE);
    ack_d      = (state_next == ACK) ? (NUM_REQ'(1) << grant_q) : '0;
    case (state)
      IDLE: if (pick_found) grant_d = pick_idx;
      WAIT_RDY: begin
        if (bus.tx_rdy) begin
          data_d     = byte_of[grant_q];
          last_d     = bus.req_last[grant_q];
          data_wen_d = 1'b0;
          cnt_d      = '0;
        end
      end
      ACCEPT: begin
        // Transmitter never took the byte: drop it and release any lock.
        if (bus.tx_rdy) begin
          cnt_d = cnt_inc;
          if (cnt_hit) begin
            err_d  = 1'b1;
            last_d = 1'b1;
          end
        end
      end
      ACK: begin
        if (last_q) ptr_d = grant_inc;
        else        cnt_d = '0;
      end
      HOLD: begin
        // Locked requester went quiet: give up the lock.
        if (!req_g) begin
          cnt_d = cnt_inc;
          if (cnt_hit) begin
            err_d = 1'b1;
            ptr_d = grant_inc;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.data        = data_q;
  assign bus.data_wen    = data_wen_q;
  assign bus.ack         = ack_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=8).
module tb_uart_tx_arbiter;
  import echo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_stuck = 1'b0;
  int   tx_cnt = 0;
  int   cyc = 0;
  logic [3:0] last_ack = '0;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: tx_rdy falls the cycle after a strobe, returns 3 later.
  assign bus.tx_rdy = tx_stuck || (tx_cnt == 0);
  always @(posedge clk or posedge rst) begin
    if (rst)                tx_cnt <= 0;
    else if (!bus.data_wen) tx_cnt <= 3;
    else if (tx_cnt != 0)   tx_cnt <= tx_cnt - 1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [1:0] exp_ack_q[$];
  logic [1:0] ack_q[$];
  int stb_cyc_q[$];
  int ack_cyc_q[$];
  int err_cyc_q[$];
  logic wide_strobe = 1'b0;
  logic prev_low = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  // Monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    last_ack = bus.ack;
    if (rst) begin
      prev_low = 1'b0;
    end else begin
      if (!bus.data_wen) begin
        got_q.push_back(bus.data);
        stb_cyc_q.push_back(cyc);
        if (prev_low) wide_strobe = 1'b1;
      end
      prev_low = !bus.data_wen;
      for (int i = 0; i < 4; i++) begin
        if (bus.ack[i]) begin
          ack_q.push_back(2'(i));
          ack_cyc_q.push_back(cyc);
        end
      end
      if (bus.timeout_err) err_cyc_q.push_back(cyc);
    end
  end

  // A requester must hold req until it has been acknowledged.
  for (genvar g = 0; g < 4; g++) begin : g_proto
    assert property (@(posedge clk) disable iff (rst)
      $fell(bus.req[g]) |-> $past(bus.ack[g]))
      else $error("protocol violation: req %0d dropped before ack", g);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- requester drivers ----------------
  logic [8:0] rmem [4][16];
  int rhead [4] = '{0, 0, 0, 0};
  int rtail [4] = '{0, 0, 0, 0};

  task automatic drive_req();
    logic [3:0]  r;
    logic [3:0]  l;
    logic [31:0] d;
    r = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (rhead[i] != rtail[i]) begin
        r[i] = 1'b1;
        l[i] = rmem[i][rhead[i]][8];
        d    = d | (32'(rmem[i][rhead[i]][7:0]) << (8 * i));
      end
    end
    bus.req      = r;
    bus.req_last = l;
    bus.req_data = d;
  endtask

  task automatic push(input int id, input logic last, input logic [7:0] b);
    rmem[id][rtail[id]] = {last, b};
    rtail[id]++;
    drive_req();
  endtask

  // One clock: retire bytes acked in the cycle just ended, present the next.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (last_ack[i] && rhead[i] != rtail[i]) rhead[i]++;
    drive_req();
  endtask

  task automatic run_acks(input int n, input int budget, input string name);
    int k = 0;
    while (ack_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check({name, "_ack_count_in_time"}, ack_q.size(), n);
    repeat (4) step();
  endtask

  task automatic compare_logs(input string name, input int exp_err);
    check({name, "_nbytes"}, got_q.size(), exp_q.size());
    foreach (exp_q[k])
      check({name, "_byte"}, (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD, 32'(exp_q[k]));
    check({name, "_nacks"}, ack_q.size(), exp_ack_q.size());
    foreach (exp_ack_q[k])
      check({name, "_ack_id"}, (k < ack_q.size()) ? 32'(ack_q[k]) : 32'hDEAD, 32'(exp_ack_q[k]));
    check({name, "_nerr"}, err_cyc_q.size(), exp_err);
    exp_q.delete();
    got_q.delete();
    exp_ack_q.delete();
    ack_q.delete();
    stb_cyc_q.delete();
    ack_cyc_q.delete();
    err_cyc_q.delete();
  endtask

  // Watchdog: the run must always end on its own.
  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // ---------------- directed tests ----------------
  initial begin
    int c0;
    int s0;
    int a0;
    int e0;
    int k;

    drive_req();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_data_wen", bus.data_wen, 1);
    check("rst_data", bus.data, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    step();

    // Single byte from requester 1; pointer moves to 2.
    push(1, 1'b1, 8'hA5);
    c0 = cyc;
    exp_q.push_back(8'hA5);
    exp_ack_q.push_back(2'd1);
    run_acks(1, 40, "single");
    s0 = (stb_cyc_q.size() > 0) ? stb_cyc_q[0] : -100;
    a0 = (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -100;
    check("single_req_to_strobe", s0 - c0, 2);
    check("single_strobe_to_ack", a0 - s0, 2);
    check("single_busy_after", bus.busy, 0);
    check("single_state_after", 32'(bus.dbg_state), 32'(IDLE));
    compare_logs("single", 0);

    // Round robin over 0,1,3 starting from pointer 2: first grant is 3.
    push(0, 1'b1, 8'h10); push(0, 1'b1, 8'h11);
    push(1, 1'b1, 8'h20); push(1, 1'b1, 8'h21);
    push(3, 1'b1, 8'h30); push(3, 1'b1, 8'h31);
    exp_q = '{8'h30, 8'h10, 8'h20, 8'h31, 8'h11, 8'h21};
    exp_ack_q = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    run_acks(6, 120, "rr");
    compare_logs("rr", 0);

    // Move the pointer to 0, then a two-byte packet competes with requester 2.
    push(3, 1'b1, 8'h55);
    exp_q.push_back(8'h55);
    exp_ack_q.push_back(2'd3);
    run_acks(1, 40, "pre_lock");
    compare_logs("pre_lock", 0);
    push(0, 1'b0, 8'h40); push(0, 1'b1, 8'h81);
    push(2, 1'b1, 8'h99);
    exp_q = '{8'h40, 8'h81, 8'h99};
    exp_ack_q = '{2'd0, 2'd0, 2'd2};
    run_acks(3, 80, "lock");
    compare_logs("lock", 0);

    // Strobe timeout: tx_rdy never falls. Pointer is 3, so 1 then 2.
    tx_stuck = 1'b1;
    push(1, 1'b0, 8'h66);
    push(2, 1'b1, 8'h77);
    exp_q = '{8'h66, 8'h77};
    exp_ack_q = '{2'd1, 2'd2};
    run_acks(2, 80, "stb_to");
    s0 = (stb_cyc_q.size() > 0) ? stb_cyc_q[0] : -100;
    a0 = (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -100;
    e0 = (err_cyc_q.size() > 0) ? err_cyc_q[0] : -100;
    check("stb_to_err_delay", e0 - s0, 8);
    check("stb_to_err_with_ack", e0 - a0, 0);
    compare_logs("stb_to", 2);
    tx_stuck = 1'b0;
    repeat (6) step();

    // Lock timeout: requester 3 goes silent after a non-final byte.
    push(3, 1'b0, 8'hC3);
    push(0, 1'b1, 8'h0A);
    exp_q = '{8'hC3, 8'h0A};
    exp_ack_q = '{2'd3, 2'd0};
    run_acks(2, 80, "lock_to");
    a0 = (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -100;
    e0 = (err_cyc_q.size() > 0) ? err_cyc_q[0] : -100;
    s0 = (stb_cyc_q.size() > 1) ? stb_cyc_q[1] : -100;
    check("lock_to_err_delay", e0 - a0, 9);
    check("lock_to_next_strobe", s0 - e0, 2);
    compare_logs("lock_to", 1);

    // Reset while the strobe is low: pointer was 1, so requester 2 is granted.
    push(2, 1'b1, 8'hEE);
    k = 0;
    @(negedge clk);
    while (bus.data_wen && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_rst_strobe_seen", bus.data_wen, 0);
    check("mid_rst_busy_before", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_data_wen", bus.data_wen, 1);
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_data", bus.data, 0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'(IDLE));
    for (int i = 0; i < 4; i++) rhead[i] = rtail[i];
    drive_req();
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    exp_q.push_back(8'hEE);
    compare_logs("mid_rst", 0);

    // After reset the pointer is 0: requester 0 before requester 3.
    push(0, 1'b1, 8'h01);
    push(3, 1'b1, 8'h03);
    exp_q = '{8'h01, 8'h03};
    exp_ack_q = '{2'd0, 2'd3};
    run_acks(2, 60, "post_rst");
    compare_logs("post_rst", 0);

    check("strobe_one_cycle", wide_strobe, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
